ceespu_fetch: RTL and testbench

// - Instruction fetch stage, directly upstream of decode. Holds the PC and drives the synchronous instruction-memory read port.
// - Presents {instruction, PC} to decode every cycle.
// - Honours the decode stall and redirects on pipeline flush (taken branch or interrupt resolved downstream).
// - Provides I_justBranched to decode so no interrupt is taken on the first instruction of a redirected stream.

---
 rtl/ceespu_fetch_pkg.sv | 5 +
 rtl/ceespu_fetch_if.sv | 21 ++
 rtl/ceespu_fetch_hold.sv | 37 +++
 rtl/ceespu_fetch.sv | 44 ++++
 tb/tb_ceespu_fetch.sv | 112 +++++++++++
 5 files changed

// File: rtl/ceespu_fetch_pkg.sv
// ceespu_fetch_pkg: constants shared by the fetch stage and decode
package ceespu_fetch_pkg;
  localparam int CEESPU_PC_W = 14;
  localparam logic [31:0] CEESPU_NOP = 32'h0000_0000;
endpackage

// File: rtl/ceespu_fetch_if.sv
// ceespu_fetch_if: decode-facing and instruction-memory signals of the fetch stage
interface ceespu_fetch_if #(parameter int PC_W = ceespu_fetch_pkg::CEESPU_PC_W);
  logic I_stall;
  logic I_flush;
  logic [PC_W-1:0] I_branch_target;
  logic [PC_W-1:0] O_imem_addr;
  logic O_imem_en;
  logic [31:0] I_imem_data;
  logic [31:0] O_instruction;
  logic [PC_W-1:0] O_PC;
  logic O_valid;
  logic O_justBranched;
  modport master (
    input I_stall, I_flush, I_branch_target, I_imem_data,
    output O_imem_addr, O_imem_en, O_instruction, O_PC, O_valid, O_justBranched
  );
  modport slave (
    output I_stall, I_flush, I_branch_target, I_imem_data,
    input O_imem_addr, O_imem_en, O_instruction, O_PC, O_valid, O_justBranched
  );
endinterface

// File: rtl/ceespu_fetch_hold.sv
// ceespu_fetch_hold: 1-entry buffer keeping the presented instruction across a stall
module ceespu_fetch_hold
  import ceespu_fetch_pkg::*;
#(
  parameter int PC_W = CEESPU_PC_W
) (
  input  logic            I_clk,
  input  logic            I_rst,
  input  logic            clr_i,
  input  logic            resp_valid_i,
  input  logic [31:0]     resp_instr_i,
  input  logic [PC_W-1:0] resp_pc_i,
  input  logic [PC_W-1:0] idle_pc_i,
  output logic [31:0]     instr_o,
  output logic [PC_W-1:0] pc_o,
  output logic            valid_o
);
  logic            hold_valid_q, hold_valid_d;
  logic [31:0]     hold_instr_q, hold_instr_d;
  logic [PC_W-1:0] hold_pc_q, hold_pc_d;
  logic            cap;
  // memory data vanishes after one cycle, so a stalled response must be copied here
  always_comb begin
    cap          = !clr_i && !hold_valid_q && resp_valid_i;
    hold_valid_d = !I_rst && !clr_i && (hold_valid_q || resp_valid_i);
    hold_instr_d = cap ? resp_instr_i : hold_instr_q;
    hold_pc_d    = cap ? resp_pc_i : hold_pc_q;
    instr_o      = hold_valid_q ? hold_instr_q : resp_valid_i ? resp_instr_i : CEESPU_NOP;
    pc_o         = hold_valid_q ? hold_pc_q : resp_valid_i ? resp_pc_i : idle_pc_i;
    valid_o      = hold_valid_q || resp_valid_i;
  end
  always_ff @(posedge I_clk) begin
    hold_valid_q <= hold_valid_d;
    hold_instr_q <= hold_instr_d;
    hold_pc_q    <= hold_pc_d;
  end
endmodule

// File: rtl/ceespu_fetch.sv
// ceespu_fetch: PC register and synchronous imem read feeding decode with stall/flush handling
module ceespu_fetch
  import ceespu_fetch_pkg::*;
#(
  parameter int PC_W = CEESPU_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic I_clk,
  input logic I_rst,
  ceespu_fetch_if.master bus
);
  logic [PC_W-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic            resp_valid_q, resp_valid_d, jb_q, jb_d;
  logic            pres_valid;
  always_comb begin
    bus.O_imem_en    = !I_rst && (bus.I_flush || !bus.I_stall);
    bus.O_imem_addr  = bus.I_flush ? bus.I_branch_target : pc_q;
    pc_d             = I_rst ? RESET_PC : bus.I_flush ? bus.I_branch_target + 1'b1 :
                       !bus.I_stall ? pc_q + 1'b1 : pc_q;
    resp_valid_d     = !I_rst && (bus.I_flush || !bus.I_stall);
    resp_pc_d        = bus.I_flush ? bus.I_branch_target : pc_q;
    jb_d             = !I_rst && (bus.I_flush || (bus.I_stall && jb_q));
    bus.O_valid      = pres_valid;
    bus.O_justBranched = jb_q && pres_valid;
  end
  always_ff @(posedge I_clk) begin
    pc_q         <= pc_d;
    resp_valid_q <= resp_valid_d;
    resp_pc_q    <= resp_pc_d;
    jb_q         <= jb_d;
  end
  ceespu_fetch_hold #(.PC_W(PC_W)) u_hold (
    .I_clk       (I_clk),
    .I_rst       (I_rst),
    .clr_i       (bus.I_flush || !bus.I_stall),
    .resp_valid_i(resp_valid_q),
    .resp_instr_i(bus.I_imem_data),
    .resp_pc_i   (resp_pc_q),
    .idle_pc_i   (pc_q),
    .instr_o     (bus.O_instruction),
    .pc_o        (bus.O_PC),
    .valid_o     (pres_valid)
  );
endmodule

// File: tb/tb_ceespu_fetch.sv
// tb_ceespu_fetch: directed self-checking bench for the fetch stage
module tb_ceespu_fetch;
  localparam logic [31:0] A = 32'hA000_0000;
  logic clk = 1'b0;
  logic rst;
  int n_run = 0;
  int n_fail = 0;
  ceespu_fetch_if bus ();
  ceespu_fetch #(.PC_W(14), .RESET_PC(14'h0000)) dut (.I_clk(clk), .I_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // memory returns A000_0000+addr after an enabled read, garbage otherwise
  always @(posedge clk) bus.I_imem_data <= bus.O_imem_en ? A + 32'(bus.O_imem_addr) : 32'hDEAD_BEEF;
  function automatic logic [47:0] pres();
    return {bus.O_valid, bus.O_justBranched, bus.O_PC, bus.O_instruction};
  endfunction
  function automatic logic [14:0] iss();
    return {bus.O_imem_en, bus.O_imem_addr};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; bus.I_stall = 1'b0; bus.I_flush = 1'b0; bus.I_branch_target = '0;
    step(); step();
    n_run++; if (pres() !== {1'b0, 1'b0, 14'h0, 32'h0}) begin n_fail++; $display("FAIL reset_pres got=%h exp=%h", pres(), {1'b0, 1'b0, 14'h0, 32'h0}); end
    n_run++; if (bus.O_imem_en !== 1'b0) begin n_fail++; $display("FAIL reset_en got=%b exp=0", bus.O_imem_en); end
    rst = 1'b0; #1;
    n_run++; if (iss() !== {1'b1, 14'h0}) begin n_fail++; $display("FAIL issue0 got=%h exp=%h", iss(), {1'b1, 14'h0}); end
    step();
    n_run++; if (iss() !== {1'b1, 14'h1}) begin n_fail++; $display("FAIL issue1 got=%h exp=%h", iss(), {1'b1, 14'h1}); end
    n_run++; if (pres() !== {1'b1, 1'b0, 14'h0, A}) begin n_fail++; $display("FAIL first_pres got=%h exp=%h", pres(), {1'b1, 1'b0, 14'h0, A}); end
    step();
    n_run++; if (iss() !== {1'b1, 14'h2}) begin n_fail++; $display("FAIL issue2 got=%h exp=%h", iss(), {1'b1, 14'h2}); end
    n_run++; if (pres() !== {1'b1, 1'b0, 14'h1, A + 32'd1}) begin n_fail++; $display("FAIL second_pres got=%h exp=%h", pres(), {1'b1, 1'b0, 14'h1, A + 32'd1}); end
  endtask
  task automatic test_stall();
    for (int k = 0; k < 20 && bus.O_PC !== 14'd5; k++) step();
    n_run++; if (pres() !== {1'b1, 1'b0, 14'd5, A + 32'd5}) begin n_fail++; $display("FAIL reach_pc5 got=%h exp=%h", pres(), {1'b1, 1'b0, 14'd5, A + 32'd5}); end
    bus.I_stall = 1'b1; #1;
    n_run++; if (bus.O_imem_en !== 1'b0) begin n_fail++; $display("FAIL stall_en0 got=%b exp=0", bus.O_imem_en); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_run++; if (pres() !== {1'b1, 1'b0, 14'd5, A + 32'd5}) begin n_fail++; $display("FAIL stall_hold%0d got=%h exp=%h", k, pres(), {1'b1, 1'b0, 14'd5, A + 32'd5}); end
      n_run++; if (bus.O_imem_en !== 1'b0) begin n_fail++; $display("FAIL stall_en%0d got=%b exp=0", k, bus.O_imem_en); end
    end
    bus.I_stall = 1'b0; #1;
    n_run++; if (iss() !== {1'b1, 14'd6}) begin n_fail++; $display("FAIL release_issue got=%h exp=%h", iss(), {1'b1, 14'd6}); end
    step();
    n_run++; if (pres() !== {1'b1, 1'b0, 14'd6, A + 32'd6}) begin n_fail++; $display("FAIL after_stall got=%h exp=%h", pres(), {1'b1, 1'b0, 14'd6, A + 32'd6}); end
  endtask
  task automatic test_flush();
    bus.I_stall = 1'b1;
    step();
    n_run++; if (pres() !== {1'b1, 1'b0, 14'd6, A + 32'd6}) begin n_fail++; $display("FAIL pre_flush_hold got=%h exp=%h", pres(), {1'b1, 1'b0, 14'd6, A + 32'd6}); end
    bus.I_flush = 1'b1; bus.I_branch_target = 14'h0100; #1;
    n_run++; if (iss() !== {1'b1, 14'h0100}) begin n_fail++; $display("FAIL flush_issue got=%h exp=%h", iss(), {1'b1, 14'h0100}); end
    step();
    bus.I_flush = 1'b0; bus.I_stall = 1'b0; #1;
    n_run++; if (pres() !== {1'b1, 1'b1, 14'h0100, A + 32'h100}) begin n_fail++; $display("FAIL flush_pres got=%h exp=%h", pres(), {1'b1, 1'b1, 14'h0100, A + 32'h100}); end
    n_run++; if (iss() !== {1'b1, 14'h0101}) begin n_fail++; $display("FAIL flush_next_issue got=%h exp=%h", iss(), {1'b1, 14'h0101}); end
    step();
    n_run++; if (pres() !== {1'b1, 1'b0, 14'h0101, A + 32'h101}) begin n_fail++; $display("FAIL jb_clear got=%h exp=%h", pres(), {1'b1, 1'b0, 14'h0101, A + 32'h101}); end
  endtask
  task automatic test_wrap();
    logic [13:0] exp_pc [4];
    exp_pc = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    bus.I_flush = 1'b1; bus.I_branch_target = 14'h3FFE;
    step();
    bus.I_flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      n_run++; if (pres() !== {1'b1, k == 0, exp_pc[k], A + 32'(exp_pc[k])}) begin n_fail++; $display("FAIL wrap%0d got=%h exp=%h", k, pres(), {1'b1, k == 0, exp_pc[k], A + 32'(exp_pc[k])}); end
    end
  endtask
  task automatic test_reset_mid_hold();
    bus.I_stall = 1'b1;
    step();
    n_run++; if (pres() !== {1'b1, 1'b0, 14'h1, A + 32'd1}) begin n_fail++; $display("FAIL rst_pre_hold got=%h exp=%h", pres(), {1'b1, 1'b0, 14'h1, A + 32'd1}); end
    rst = 1'b1;
    step();
    n_run++; if (pres() !== {1'b0, 1'b0, 14'h0, 32'h0}) begin n_fail++; $display("FAIL rst_mid_hold got=%h exp=%h", pres(), {1'b0, 1'b0, 14'h0, 32'h0}); end
    n_run++; if (bus.O_imem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_en got=%b exp=0", bus.O_imem_en); end
    rst = 1'b0; bus.I_stall = 1'b0;
    step();
    n_run++; if (pres() !== {1'b1, 1'b0, 14'h0, A}) begin n_fail++; $display("FAIL rst_restart got=%h exp=%h", pres(), {1'b1, 1'b0, 14'h0, A}); end
  endtask
  task automatic test_back_to_back();
    bus.I_stall = 1'b1; bus.I_flush = 1'b1; bus.I_branch_target = 14'h0020; #1;
    n_run++; if (iss() !== {1'b1, 14'h0020}) begin n_fail++; $display("FAIL b2b_issue20 got=%h exp=%h", iss(), {1'b1, 14'h0020}); end
    step();
    n_run++; if (pres() !== {1'b1, 1'b1, 14'h0020, A + 32'h20}) begin n_fail++; $display("FAIL b2b_pres20 got=%h exp=%h", pres(), {1'b1, 1'b1, 14'h0020, A + 32'h20}); end
    bus.I_branch_target = 14'h0040;
    step();
    n_run++; if (pres() !== {1'b1, 1'b1, 14'h0040, A + 32'h40}) begin n_fail++; $display("FAIL b2b_pres40 got=%h exp=%h", pres(), {1'b1, 1'b1, 14'h0040, A + 32'h40}); end
    bus.I_flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_run++; if (pres() !== {1'b1, 1'b1, 14'h0040, A + 32'h40}) begin n_fail++; $display("FAIL b2b_held%0d got=%h exp=%h", k, pres(), {1'b1, 1'b1, 14'h0040, A + 32'h40}); end
    end
  endtask
  initial begin
    test_reset();
    test_stall();
    test_flush();
    test_wrap();
    test_reset_mid_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
